// File: rtl/des_perm_pipe_pkg.sv
package des_pkg;

  typedef enum logic [1:0] {
    DES_MODE_IP  = 2'b00,
    DES_MODE_FP  = 2'b01,
    DES_MODE_BYP = 2'b10,
    DES_MODE_RSV = 2'b11
  } des_mode_e;

  // Standard DES IP table, 1-based source bit numbers; out[i] = in[DES_IP_TBL[i]-1].
  localparam int unsigned DES_IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  function automatic logic [63:0] des_ip(input logic [63:0] d);
    logic [63:0] r;
    logic [5:0]  idx;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      idx        = 6'(DES_IP_TBL[6'(i)] - 1);
      r[6'(i)]   = d[idx];
    end
    return r;
  endfunction

  // FP is the inverse mapping: scatter through the IP table instead of gathering.
  function automatic logic [63:0] des_fp(input logic [63:0] d);
    logic [63:0] r;
    logic [5:0]  idx;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      idx    = 6'(DES_IP_TBL[6'(i)] - 1);
      r[idx] = d[6'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_pipe_stage.sv
module des_pipe_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [63:0]      up_data,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             dn_ready,
  output logic             valid,
  output logic [63:0]      data,
  output logic [TAG_W-1:0] tag
);

  logic             valid_q, valid_d;
  logic [63:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             take;

  always_comb begin
    take    = up_valid && (!valid_q || dn_ready);
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (valid_q && dn_ready) begin
      valid_d = 1'b0;
    end
    if (take) begin
      valid_d = 1'b1;
      data_d  = up_data;
      tag_d   = up_tag;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign tag   = tag_q;

endmodule

// File: rtl/des_perm_pipe.sv
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       occupancy,
  output logic             err_sticky
);

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("des_perm_pipe: PIPE_DEPTH must be in 1..4");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
    $error("des_perm_pipe: TAG_W must be in 1..16");
  end

  logic [PIPE_DEPTH-1:0] stg_valid;
  logic [PIPE_DEPTH-1:0] stg_dn_ready;
  logic [63:0]           stg_data [PIPE_DEPTH];
  logic [TAG_W-1:0]      stg_tag  [PIPE_DEPTH];

  des_mode_e   mode;
  logic [63:0] perm_data;
  logic        accept;
  logic        emit;
  logic        err_sticky_q, err_sticky_d;
  logic [2:0]  occupancy_q, occupancy_d;

  always_comb begin
    mode      = des_mode_e'(in_mode);
    perm_data = in_data;
    case (mode)
      DES_MODE_IP: perm_data = des_ip(in_data);
      DES_MODE_FP: perm_data = des_fp(in_data);
      default:     perm_data = in_data;
    endcase
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [63:0]      up_data;
    logic [TAG_W-1:0] up_tag;

    if (k == 0) begin : g_head
      assign up_valid = in_valid && !flush;
      assign up_data  = perm_data;
      assign up_tag   = in_tag;
    end else begin : g_body
      assign up_valid = stg_valid[k-1];
      assign up_data  = stg_data[k-1];
      assign up_tag   = stg_tag[k-1];
    end

    // Ready chain flattened: downstream of stage k can take a word when
    // out_ready is high or any later stage is empty.
    if (k == PIPE_DEPTH - 1) begin : g_last
      assign stg_dn_ready[k] = out_ready;
    end else begin : g_mid
      assign stg_dn_ready[k] = out_ready || !(&stg_valid[PIPE_DEPTH-1:k+1]);
    end

    des_pipe_stage #(
      .TAG_W(TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .up_valid(up_valid),
      .up_data (up_data),
      .up_tag  (up_tag),
      .dn_ready(stg_dn_ready[k]),
      .valid   (stg_valid[k]),
      .data    (stg_data[k]),
      .tag     (stg_tag[k])
    );
  end

  assign in_ready = !flush && (!stg_valid[0] || stg_dn_ready[0]);
  assign accept   = in_valid && in_ready;
  assign emit     = stg_valid[PIPE_DEPTH-1] && out_ready;

  always_comb begin
    err_sticky_d = err_sticky_q;
    occupancy_d  = occupancy_q;
    if (accept && mode == DES_MODE_RSV) begin
      err_sticky_d = 1'b1;
    end
    if (accept && !emit) begin
      occupancy_d = occupancy_q + 3'd1;
    end else if (!accept && emit) begin
      occupancy_d = occupancy_q - 3'd1;
    end
    if (flush) begin
      err_sticky_d = 1'b0;
      occupancy_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
      occupancy_q  <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      occupancy_q  <= occupancy_d;
    end
  end

  assign out_valid  = stg_valid[PIPE_DEPTH-1];
  assign out_data   = stg_data[PIPE_DEPTH-1];
  assign out_tag    = stg_tag[PIPE_DEPTH-1];
  assign occupancy  = occupancy_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
module tb_des_perm_pipe;

  localparam int unsigned N_DUT = 3;
  localparam int unsigned TAG_W = 4;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7
  };
  localparam int unsigned FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam logic [1:0]       KV_MODE [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
  localparam logic [63:0]      KV_IN   [6] = '{64'h0000000000000001, 64'h0000008000000000,
                                               64'h0200000000000000, 64'hFFFFFFFFFFFFFFFF,
                                               64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
  localparam logic [63:0]      KV_EXP  [6] = '{64'h0000008000000000, 64'h0000000000000001,
                                               64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF,
                                               64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
  localparam logic [TAG_W-1:0] KV_TAG  [6] = '{4'd3, 4'd5, 4'd7, 4'd1, 4'd2, 4'd9};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             flush;
  logic             in_valid   [N_DUT];
  logic             in_ready   [N_DUT];
  logic [1:0]       in_mode    [N_DUT];
  logic [63:0]      in_data    [N_DUT];
  logic [TAG_W-1:0] in_tag     [N_DUT];
  logic             out_valid  [N_DUT];
  logic             out_ready  [N_DUT];
  logic [63:0]      out_data   [N_DUT];
  logic [TAG_W-1:0] out_tag    [N_DUT];
  logic [2:0]       occupancy  [N_DUT];
  logic             err_sticky [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    des_perm_pipe #(
      .PIPE_DEPTH((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
      .TAG_W     (TAG_W)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_mode   (in_mode[g]),
      .in_data   (in_data[g]),
      .in_tag    (in_tag[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_tag   (out_tag[g]),
      .occupancy (occupancy[g]),
      .err_sticky(err_sticky[g])
    );
  end

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    int unsigned      cyc;
  } exp_t;

  exp_t sb [$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic int unsigned depth_of(input int unsigned s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
  endfunction

  function automatic logic [63:0] model(input logic [1:0] m, input logic [63:0] d);
    logic [63:0] r;
    r = d;
    if (m == 2'b00) begin
      for (int i = 0; i < 64; i++) r[6'(i)] = d[6'(IP_T[6'(i)] - 1)];
    end else if (m == 2'b01) begin
      for (int i = 0; i < 64; i++) r[6'(i)] = d[6'(FP_T[6'(i)] - 1)];
    end
    return r;
  endfunction

  task automatic idle_all();
    for (int s = 0; s < int'(N_DUT); s++) begin
      in_valid[s]  = 1'b0;
      in_mode[s]   = 2'b00;
      in_data[s]   = '0;
      in_tag[s]    = '0;
      out_ready[s] = 1'b1;
    end
  endtask

  // Drives one word into DUT s and waits (bounded) for it to appear at the output.
  task automatic xfer(input int unsigned s, input logic [1:0] m, input logic [63:0] d,
                      input logic [TAG_W-1:0] t, output logic [63:0] got_d,
                      output logic [TAG_W-1:0] got_t, output int unsigned lat,
                      output logic acc_ok, output logic out_ok);
    int unsigned w;
    @(negedge clk);
    in_valid[s] = 1'b1; in_mode[s] = m; in_data[s] = d; in_tag[s] = t; out_ready[s] = 1'b1;
    #1;
    w = 0;
    while (!in_ready[s] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    acc_ok = in_ready[s];
    @(negedge clk);
    in_valid[s] = 1'b0;
    lat = 1;
    #1;
    while (!out_valid[s] && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    out_ok = out_valid[s];
    got_d  = out_data[s];
    got_t  = out_tag[s];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    for (int s = 0; s < int'(N_DUT); s++) begin
      n_cmp++; if (out_valid[s] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid dut%0d: got %b want 0", s, out_valid[s]); end
      n_cmp++; if (occupancy[s] !== 3'd0) begin n_err++; $display("FAIL reset_occupancy dut%0d: got %0d want 0", s, occupancy[s]); end
      n_cmp++; if (err_sticky[s] !== 1'b0) begin n_err++; $display("FAIL reset_err dut%0d: got %b want 0", s, err_sticky[s]); end
      n_cmp++; if (out_data[s] !== 64'h0) begin n_err++; $display("FAIL reset_out_data dut%0d: got %h want 0", s, out_data[s]); end
      n_cmp++; if (out_tag[s] !== '0) begin n_err++; $display("FAIL reset_out_tag dut%0d: got %h want 0", s, out_tag[s]); end
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int s = 0; s < int'(N_DUT); s++) begin
      n_cmp++; if (in_ready[s] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready dut%0d: got %b want 1", s, in_ready[s]); end
    end
  endtask

  task automatic test_known_vectors();
    logic [63:0]      gd;
    logic [TAG_W-1:0] gt;
    int unsigned      lat;
    logic             aok, ook;
    for (int k = 0; k < 6; k++) begin
      xfer(1, KV_MODE[3'(k)], KV_IN[3'(k)], KV_TAG[3'(k)], gd, gt, lat, aok, ook);
      n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL kv%0d_accept: got %b want 1", k, aok); end
      n_cmp++; if (ook !== 1'b1) begin n_err++; $display("FAIL kv%0d_out_valid: got %b want 1", k, ook); end
      n_cmp++; if (gd !== KV_EXP[3'(k)]) begin n_err++; $display("FAIL kv%0d_data: got %h want %h", k, gd, KV_EXP[3'(k)]); end
      n_cmp++; if (gt !== KV_TAG[3'(k)]) begin n_err++; $display("FAIL kv%0d_tag: got %h want %h", k, gt, KV_TAG[3'(k)]); end
      n_cmp++; if (lat != 2) begin n_err++; $display("FAIL kv%0d_latency: got %0d want 2", k, lat); end
    end
  endtask

  task automatic test_roundtrip();
    logic [63:0]      x, y, z;
    logic [TAG_W-1:0] gt;
    int unsigned      lat;
    logic             aok, ook;
    for (int k = 0; k < 8; k++) begin
      x = {$urandom, $urandom};
      xfer(1, 2'b00, x, TAG_W'(k), y, gt, lat, aok, ook);
      n_cmp++; if (y !== model(2'b00, x)) begin n_err++; $display("FAIL rt%0d_ip: got %h want %h", k, y, model(2'b00, x)); end
      xfer(1, 2'b01, y, TAG_W'(k), z, gt, lat, aok, ook);
      n_cmp++; if (z !== x) begin n_err++; $display("FAIL rt%0d_fp_ip: got %h want %h", k, z, x); end
    end
  endtask

  task automatic test_stream(input int unsigned s, input int unsigned n, input logic stall);
    int unsigned cyc, sent, dep, limit;
    logic        prev_fire, exp_rdy;
    exp_t        e;
    cyc = 0; sent = 0; dep = depth_of(s); limit = 30 * n + 200; prev_fire = 1'b0;
    sb.delete();
    while ((sent < n || sb.size() != 0) && cyc < limit) begin
      @(negedge clk);
      if (!(in_valid[s] && !prev_fire)) begin
        if (sent < n && (!stall || $urandom_range(0, 3) != 0)) begin
          in_valid[s] = 1'b1;
          in_mode[s]  = 2'($urandom_range(0, 3));
          in_data[s]  = {$urandom, $urandom};
          in_tag[s]   = TAG_W'($urandom);
        end else begin
          in_valid[s] = 1'b0;
        end
      end
      out_ready[s] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      exp_rdy = !(sb.size() == int'(dep) && !out_ready[s]);
      n_cmp++; if (occupancy[s] !== 3'(sb.size())) begin n_err++; $display("FAIL st%0d_occupancy cyc %0d: got %0d want %0d", s, cyc, occupancy[s], sb.size()); end
      n_cmp++; if (in_ready[s] !== exp_rdy) begin n_err++; $display("FAIL st%0d_in_ready cyc %0d: got %b want %b", s, cyc, in_ready[s], exp_rdy); end
      if (out_valid[s] && out_ready[s]) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL st%0d_spurious cyc %0d: got word %h want none", s, cyc, out_data[s]);
        end else begin
          e = sb.pop_front();
          n_cmp++; if (out_data[s] !== e.data) begin n_err++; $display("FAIL st%0d_data cyc %0d: got %h want %h", s, cyc, out_data[s], e.data); end
          n_cmp++; if (out_tag[s] !== e.tag) begin n_err++; $display("FAIL st%0d_tag cyc %0d: got %h want %h", s, cyc, out_tag[s], e.tag); end
          if (!stall) begin
            n_cmp++; if (cyc - e.cyc != dep) begin n_err++; $display("FAIL st%0d_latency cyc %0d: got %0d want %0d", s, cyc, cyc - e.cyc, dep); end
          end
        end
      end
      prev_fire = in_valid[s] && in_ready[s];
      if (prev_fire) begin
        e.data = model(in_mode[s], in_data[s]);
        e.tag  = in_tag[s];
        e.cyc  = cyc;
        sb.push_back(e);
        sent++;
      end
      cyc++;
    end
    n_cmp++; if (sent != n || sb.size() != 0) begin n_err++; $display("FAIL st%0d_timeout: got sent %0d pending %0d want sent %0d pending 0", s, sent, sb.size(), n); end
    in_valid[s]  = 1'b0;
    out_ready[s] = 1'b1;
  endtask

  task automatic test_reserved_flush();
    @(negedge clk);
    flush = 1'b1; in_valid[1] = 1'b1; in_mode[1] = 2'b00; in_data[1] = 64'h1122334455667788; out_ready[1] = 1'b0;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL rf_pre_flush_ready: got %b want 0", in_ready[1]); end
    @(negedge clk);
    flush = 1'b0; in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (err_sticky[1] !== 1'b0) begin n_err++; $display("FAIL rf_pre_err: got %b want 0", err_sticky[1]); end
    n_cmp++; if (occupancy[1] !== 3'd0) begin n_err++; $display("FAIL rf_pre_occ: got %0d want 0", occupancy[1]); end
    in_valid[1] = 1'b1; in_mode[1] = 2'b11; in_data[1] = 64'hDEADBEEF01234567; in_tag[1] = 4'hA;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL rf_rsv_ready: got %b want 1", in_ready[1]); end
    n_cmp++; if (err_sticky[1] !== 1'b0) begin n_err++; $display("FAIL rf_err_before_accept: got %b want 0", err_sticky[1]); end
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (err_sticky[1] !== 1'b1) begin n_err++; $display("FAIL rf_err_after_accept: got %b want 1", err_sticky[1]); end
    n_cmp++; if (occupancy[1] !== 3'd1) begin n_err++; $display("FAIL rf_occ1: got %0d want 1", occupancy[1]); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid[1] !== 1'b1) begin n_err++; $display("FAIL rf_out_valid: got %b want 1", out_valid[1]); end
    n_cmp++; if (out_data[1] !== 64'hDEADBEEF01234567) begin n_err++; $display("FAIL rf_rsv_data: got %h want deadbeef01234567", out_data[1]); end
    n_cmp++; if (out_tag[1] !== 4'hA) begin n_err++; $display("FAIL rf_rsv_tag: got %h want a", out_tag[1]); end
    in_valid[1] = 1'b1; in_mode[1] = 2'b00; in_data[1] = 64'h0F0F0F0F0F0F0F0F; in_tag[1] = 4'h5;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL rf_second_ready: got %b want 1", in_ready[1]); end
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (occupancy[1] !== 3'd2) begin n_err++; $display("FAIL rf_occ2: got %0d want 2", occupancy[1]); end
    n_cmp++; if (out_data[1] !== 64'hDEADBEEF01234567) begin n_err++; $display("FAIL rf_hold_data: got %h want deadbeef01234567", out_data[1]); end
    flush = 1'b1; in_valid[1] = 1'b1; in_data[1] = 64'h5555AAAA5555AAAA;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL rf_flush_ready: got %b want 0", in_ready[1]); end
    @(negedge clk);
    flush = 1'b0; in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL rf_flush_out_valid: got %b want 0", out_valid[1]); end
    n_cmp++; if (occupancy[1] !== 3'd0) begin n_err++; $display("FAIL rf_flush_occ: got %0d want 0", occupancy[1]); end
    n_cmp++; if (err_sticky[1] !== 1'b0) begin n_err++; $display("FAIL rf_flush_err: got %b want 0", err_sticky[1]); end
    @(negedge clk); #1;
    n_cmp++; if (occupancy[1] !== 3'd0) begin n_err++; $display("FAIL rf_flush_no_accept_occ: got %0d want 0", occupancy[1]); end
    n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL rf_flush_no_accept_valid: got %b want 0", out_valid[1]); end
    out_ready[1] = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1; in_mode[1] = 2'b00; in_data[1] = 64'hCAFEF00D12345678; in_tag[1] = 4'h1;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL ar_fill0_ready: got %b want 1", in_ready[1]); end
    @(negedge clk);
    in_data[1] = 64'h8765432100FFEE11; in_tag[1] = 4'h2;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL ar_fill1_ready: got %b want 1", in_ready[1]); end
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (occupancy[1] !== 3'd2) begin n_err++; $display("FAIL ar_full_occ: got %0d want 2", occupancy[1]); end
    n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL ar_full_ready: got %b want 0", in_ready[1]); end
    n_cmp++; if (out_valid[1] !== 1'b1) begin n_err++; $display("FAIL ar_full_valid: got %b want 1", out_valid[1]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL ar_async_valid: got %b want 0", out_valid[1]); end
    n_cmp++; if (occupancy[1] !== 3'd0) begin n_err++; $display("FAIL ar_async_occ: got %0d want 0", occupancy[1]); end
    n_cmp++; if (out_data[1] !== 64'h0) begin n_err++; $display("FAIL ar_async_data: got %h want 0", out_data[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL ar_release_ready: got %b want 1", in_ready[1]); end
    out_ready[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL ar_no_output%0d: got %b want 0", k, out_valid[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_roundtrip();
    for (int s = 0; s < int'(N_DUT); s++) test_stream(s, 40, 1'b0);
    for (int s = 0; s < int'(N_DUT); s++) test_stream(s, 100, 1'b1);
    test_reserved_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
Parametrised, elastic, pipelined DES permutation unit. It is the registered successor to the combinational initial-permutation logic. One datapath applies the DES initial permutation (IP), the final permutation (FP = IP^-1) or a bypass, selected per transaction. It uses valid/ready handshakes with a sideband tag, and sits between the block-input FIFO / round core and between the round core / output stage of the DES engine.

Parameters:
PIPE_DEPTH, 2, number of register stages (legal 1..4); elaboration error outside this range.
TAG_W, 4, width of opaque sideband tag carried with each word (legal 1..16).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all in-flight words and err_sticky.
in_valid  input  1  upstream word valid.
in_ready  output  1  unit can accept a word this cycle.
in_mode  input  2  00=IP, 01=FP, 10=bypass, 11=reserved.
in_data  input  64  word; bit 0 = DES bit 1 (MSB-first DES numbering mapped to index-1).
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  output word valid.
out_ready  input  1  downstream accepts.
out_data  output  64  permuted word.
out_tag  output  TAG_W  tag of out_data.
occupancy  output  3  number of valid stages (0..PIPE_DEPTH).
err_sticky  output  1  set when a mode-11 word is accepted.

Behaviour:
- Reset (rst_n=0, async): all stage valid bits=0, data/tag regs=0, out_valid=0, out_data=0, out_tag=0, occupancy=0, err_sticky=0. in_ready=1 once reset deasserts.
- Permutation is applied combinationally on in_data and captured into stage 0. Later stages pass the word through unchanged.
- IP: out[i] = in[IP[i]-1] with the standard DES IP table; e.g. out[0]=in[57], out[1]=in[49], out[7]=in[1], out[32]=in[56], out[39]=in[0], out[63]=in[6].
- FP: exact inverse of IP; out[0]=in[39], out[1]=in[7], out[63]=in[24]. FP(IP(x))=x for all x.
- Bypass and reserved (11): data passes unmodified. Reserved additionally sets err_sticky on the acceptance cycle.
- Handshake: transfer occurs on valid&&ready. in_valid/data/mode/tag must be held stable while in_valid=1 and in_ready=0. out_valid, once high, stays high with stable out_data/out_tag until out_ready.
- Stage k advances when stage k+1 is empty or stage k+1 is advancing. The last stage advances when out_ready=1. in_ready = !valid[0] || stage 0 advancing, i.e. combinational through the chain; no bubble on full flow.
- Latency: PIPE_DEPTH cycles from acceptance to out_valid with out_ready held 1. Throughput: 1 word/cycle.
- Backpressure: with out_ready=0 the pipe fills. in_ready drops after PIPE_DEPTH accepted words, at occupancy==PIPE_DEPTH. No word is dropped or duplicated.
- occupancy = popcount of stage valid bits, registered. Simultaneous accept and emit leaves it unchanged.
- flush: next edge clears all valid bits and err_sticky. flush dominates a simultaneous in_valid, so the word is not accepted and in_ready=0 during flush. out_valid falls the cycle after flush.
- Reset mid-stream: all words are lost, with no partial output.
- Ordering is strictly FIFO; the tag travels with its word.

Decomposition:
- Package des_pkg: mode encodings (DES_MODE_IP, DES_MODE_FP, DES_MODE_BYP, DES_MODE_RSV), 64-entry IP index table constant, and functions des_ip(), des_fp() (FP derived by inverting the table).
- One sub-module: des_pipe_stage (one valid/data/tag register with advance logic), instantiated PIPE_DEPTH times by generate.

Test Plan:
1. IP, PIPE_DEPTH=2, out_ready=1: in_data=64'h0000000000000001, tag=3 -> out_data=64'h0000008000000000, tag=3, exactly 2 cycles after accept.
2. FP of 64'h0000008000000000 -> 64'h0000000000000001. IP of 64'h0200000000000000 -> 64'h0000000000000001. All-ones in any mode -> all-ones.
3. Back-to-back 100 random words with mixed modes, random out_ready stalls -> scoreboard match, FIFO order, FP(IP(x))=x, in_ready falls exactly when occupancy=PIPE_DEPTH.
4. Mode 11 word 64'hDEADBEEF01234567 -> output unmodified, err_sticky=1 from the cycle after accept. A subsequent flush clears err_sticky and empties the pipe (out_valid=0, occupancy=0 next cycle).
5. out_ready=0 with pipe full, assert rst_n=0 mid-cycle -> out_valid=0 and occupancy=0 immediately (async), in_ready=1 after release.
6. Sweep PIPE_DEPTH=1 and 4 with scenario 3 -> latency 1 and 4 respectively, full throughput.
